// File: rtl/cmd_sym_pkg.sv
// ---------------------------------------------------------------------------
// cmd_sym_pkg
// Shared definitions for the 2-bit command-symbol link, used by both the
// transmitter (cmd_symbol_tx) and the Moore-style symbol decoder.
//   SYM_*       : symbol codes carried on the 2-bit bus
//   tx_state_t  : transmitter FSM state encoding
//   is_code()   : true for any symbol other than idle
// ---------------------------------------------------------------------------
package cmd_sym_pkg;

    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_CLR  = 2'b01;
    localparam logic [1:0] SYM_TGL  = 2'b10;
    localparam logic [1:0] SYM_SET  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10
    } tx_state_t;

    function automatic logic is_code(input logic [1:0] sym);
        return sym != SYM_IDLE;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Small synchronous FIFO holding queued command symbols.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low, flushes the FIFO to empty
//   i_push   : write i_wdata (ignored when full)
//   i_wdata  : data to write
//   i_pop    : advance the read pointer (ignored when empty)
//   o_rdata  : head-of-queue data (valid when not empty)
//   o_full   : DEPTH entries held
//   o_empty  : no entries held
//   o_count  : number of entries held
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_symbol_tx.sv
// ---------------------------------------------------------------------------
// cmd_symbol_tx
// Transmit side of the 2-bit command-symbol link. Commands arrive over a
// valid/ready handshake, are queued, and are serialised as a code symbol held
// for HOLD_CYCLES followed by GAP_CYCLES of idle.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low
//   cmd_valid   : command present
//   cmd         : 01 clear, 10 toggle, 11 set, 00 illegal
//   cmd_ready   : command accepted when valid and ready on an edge
//   aout        : registered symbol stream to the decoder
//   busy        : FSM active or commands still queued
//   fifo_count  : queued entries
//   err_illegal : one-cycle pulse after an accepted 00 command
// ---------------------------------------------------------------------------
import cmd_sym_pkg::*;

module cmd_symbol_tx #(
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    input  logic [1:0]                    cmd,
    output logic                          cmd_ready,
    output logic [1:0]                    aout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_illegal
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    tx_state_t     r_state;
    tx_state_t     w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [1:0]    r_aout;
    logic [1:0]    w_aout_next;
    logic          r_err_illegal;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [1:0]    w_head;

    // Ready is a plain compare on the registered count, held low during reset.
    assign cmd_ready = reset & ~w_full;
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_push    = w_accept & is_code(cmd);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (cmd),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign aout        = r_aout;
    assign err_illegal = r_err_illegal;
    assign busy        = (r_state != ST_IDLE) | ~w_empty;

    // Next-state logic. GAP chains straight into SEND when more work is
    // queued so back-to-back commands have no extra idle cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_aout_next  = r_aout;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_aout_next = SYM_IDLE;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_aout_next  = w_head;
                    w_cnt_next   = HOLD_LOAD;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_aout_next  = SYM_IDLE;
                    w_cnt_next   = GAP_LOAD;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                w_aout_next = SYM_IDLE;
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_aout_next  = w_head;
                    w_cnt_next   = HOLD_LOAD;
                    w_state_next = ST_SEND;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_aout_next  = SYM_IDLE;
                w_cnt_next   = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers; reset drops aout to idle at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_aout        <= SYM_IDLE;
            r_err_illegal <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_aout        <= w_aout_next;
            r_err_illegal <= w_accept & ~is_code(cmd);
        end
    end

endmodule

// File: tb/tb_cmd_symbol_tx.sv
// ---------------------------------------------------------------------------
// tb_cmd_symbol_tx
// Directed bench for cmd_symbol_tx. Two instances share clock and reset:
// one with default timing, one with HOLD_CYCLES=3 / GAP_CYCLES=4. A small
// decoder model watches each aout stream and counts emitted commands.
// ---------------------------------------------------------------------------
module tb_cmd_symbol_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       validDef = 1'b0;
    logic [1:0] cmdDef = 2'b00;
    logic       readyDef;
    logic [1:0] aoutDef;
    logic       busyDef;
    logic [2:0] countDef;
    logic       errDef;

    logic       validH3 = 1'b0;
    logic [1:0] cmdH3 = 2'b00;
    logic       readyH3;
    logic [1:0] aoutH3;
    logic       busyH3;
    logic [2:0] countH3;
    logic       errH3;

    int vectors = 0;
    int miscompares = 0;

    // Decoder model state
    logic [1:0] prevDef = 2'b00;
    logic [1:0] prevH3 = 2'b00;
    logic       yDef = 1'b0;
    logic       yH3 = 1'b0;
    int nSetDef = 0, nClrDef = 0, nTglDef = 0, errCntDef = 0;
    int nSetH3 = 0, nClrH3 = 0, nTglH3 = 0;

    always #5 clk = ~clk;

    cmd_symbol_tx dutDef (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (validDef),
        .cmd         (cmdDef),
        .cmd_ready   (readyDef),
        .aout        (aoutDef),
        .busy        (busyDef),
        .fifo_count  (countDef),
        .err_illegal (errDef)
    );

    cmd_symbol_tx #(
        .HOLD_CYCLES (3),
        .GAP_CYCLES  (4),
        .FIFO_DEPTH  (4)
    ) dutH3 (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (validH3),
        .cmd         (cmdH3),
        .cmd_ready   (readyH3),
        .aout        (aoutH3),
        .busy        (busyH3),
        .fifo_count  (countH3),
        .err_illegal (errH3)
    );

    // Decoder model: a command takes effect when a code follows idle
    always @(negedge clk) begin
        if (!reset) begin
            prevDef = 2'b00;
            prevH3  = 2'b00;
            yDef    = 1'b0;
            yH3     = 1'b0;
        end else begin
            if (aoutDef != 2'b00 && prevDef == 2'b00) begin
                case (aoutDef)
                    2'b01:   begin yDef = 1'b0; nClrDef++; end
                    2'b10:   begin yDef = ~yDef; nTglDef++; end
                    default: begin yDef = 1'b1; nSetDef++; end
                endcase
            end
            prevDef = aoutDef;
            if (errDef) errCntDef++;
            if (aoutH3 != 2'b00 && prevH3 == 2'b00) begin
                case (aoutH3)
                    2'b01:   begin yH3 = 1'b0; nClrH3++; end
                    2'b10:   begin yH3 = ~yH3; nTglH3++; end
                    default: begin yH3 = 1'b1; nSetH3++; end
                endcase
            end
            prevH3 = aoutH3;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (aoutDef !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_aout got %b want 00", aoutDef); end
        vectors++; if (busyDef !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy got %b want 0", busyDef); end
        vectors++; if (countDef !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_count got %0d want 0", countDef); end
        vectors++; if (errDef !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_err got %b want 0", errDef); end
        vectors++; if (readyDef !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ready got %b want 0", readyDef); end
        vectors++; if (aoutH3 !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_aoutH3 got %b want 00", aoutH3); end
        step();
        step();
        reset = 1'b1;
        #1;
        vectors++; if (readyDef !== 1'b1) begin miscompares++; $display("[TB] FAIL rel_ready got %b want 1", readyDef); end
        vectors++; if (readyH3 !== 1'b1) begin miscompares++; $display("[TB] FAIL rel_readyH3 got %b want 1", readyH3); end
    endtask

    task automatic test_single_set();
        int baseSet;
        baseSet = nSetDef;
        validDef = 1'b1; cmdDef = 2'b11;
        step();
        validDef = 1'b0;
        vectors++; if (countDef !== 3'd1) begin miscompares++; $display("[TB] FAIL set_count0 got %0d want 1", countDef); end
        vectors++; if (aoutDef !== 2'b00) begin miscompares++; $display("[TB] FAIL set_aout0 got %b want 00", aoutDef); end
        vectors++; if (busyDef !== 1'b1) begin miscompares++; $display("[TB] FAIL set_busy0 got %b want 1", busyDef); end
        step();
        vectors++; if (aoutDef !== 2'b11) begin miscompares++; $display("[TB] FAIL set_aout1 got %b want 11", aoutDef); end
        vectors++; if (countDef !== 3'd0) begin miscompares++; $display("[TB] FAIL set_count1 got %0d want 0", countDef); end
        step();
        vectors++; if (aoutDef !== 2'b00) begin miscompares++; $display("[TB] FAIL set_aout2 got %b want 00", aoutDef); end
        step();
        vectors++; if (aoutDef !== 2'b00) begin miscompares++; $display("[TB] FAIL set_aout3 got %b want 00", aoutDef); end
        vectors++; if (busyDef !== 1'b1) begin miscompares++; $display("[TB] FAIL set_busy3 got %b want 1", busyDef); end
        step();
        vectors++; if (busyDef !== 1'b0) begin miscompares++; $display("[TB] FAIL set_busy4 got %b want 0", busyDef); end
        vectors++; if (yDef !== 1'b1) begin miscompares++; $display("[TB] FAIL set_yout got %b want 1", yDef); end
        vectors++; if (nSetDef - baseSet !== 1) begin miscompares++; $display("[TB] FAIL set_nset got %0d want 1", nSetDef - baseSet); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] expSeq [9];
        expSeq = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        validDef = 1'b1; cmdDef = 2'b11;
        step();
        for (int i = 0; i < 9; i++) begin
            if (i == 0) cmdDef = 2'b10;
            else if (i == 1) cmdDef = 2'b01;
            else validDef = 1'b0;
            step();
            vectors++;
            if (aoutDef !== expSeq[i]) begin
                miscompares++;
                $display("[TB] FAIL b2b_aout[%0d] got %b want %b", i, aoutDef, expSeq[i]);
            end
            if (i == 2) begin
                vectors++; if (yDef !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_yset got %b want 1", yDef); end
            end
            if (i == 5) begin
                vectors++; if (yDef !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_ytgl got %b want 0", yDef); end
            end
            if (i == 8) begin
                vectors++; if (yDef !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_yclr got %b want 0", yDef); end
                vectors++; if (busyDef !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_busy9 got %b want 1", busyDef); end
            end
        end
        step();
        vectors++; if (busyDef !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_busy10 got %b want 0", busyDef); end
    endtask

    task automatic test_fill();
        logic [2:0] expCount [8];
        logic       expReady [8];
        int baseTgl;
        int waited;
        expCount = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
        expReady = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        baseTgl = nTglH3;
        validH3 = 1'b1; cmdH3 = 2'b10;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (countH3 !== expCount[i]) begin
                miscompares++;
                $display("[TB] FAIL fill_count[%0d] got %0d want %0d", i, countH3, expCount[i]);
            end
            vectors++;
            if (readyH3 !== expReady[i]) begin
                miscompares++;
                $display("[TB] FAIL fill_ready[%0d] got %b want %b", i, readyH3, expReady[i]);
            end
        end
        validH3 = 1'b0;
        waited = 0;
        while (busyH3 && waited < 80) begin step(); waited++; end
        vectors++; if (busyH3 !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_idle_timeout busy got %b want 0", busyH3); end
        step();
        vectors++; if (nTglH3 - baseTgl !== 5) begin miscompares++; $display("[TB] FAIL fill_toggles got %0d want 5", nTglH3 - baseTgl); end
    endtask

    task automatic test_illegal();
        int baseSet, baseClr, baseTgl, baseErr;
        int waited;
        baseSet = nSetDef; baseClr = nClrDef; baseTgl = nTglDef; baseErr = errCntDef;
        validDef = 1'b1; cmdDef = 2'b00;
        step();
        vectors++; if (errDef !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_err0 got %b want 1", errDef); end
        vectors++; if (countDef !== 3'd0) begin miscompares++; $display("[TB] FAIL ill_count0 got %0d want 0", countDef); end
        cmdDef = 2'b11;
        step();
        validDef = 1'b0;
        vectors++; if (errDef !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_err1 got %b want 0", errDef); end
        vectors++; if (countDef !== 3'd1) begin miscompares++; $display("[TB] FAIL ill_count1 got %0d want 1", countDef); end
        waited = 0;
        while (busyDef && waited < 20) begin step(); waited++; end
        vectors++; if (busyDef !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_idle_timeout busy got %b want 0", busyDef); end
        step();
        vectors++; if (errCntDef - baseErr !== 1) begin miscompares++; $display("[TB] FAIL ill_pulses got %0d want 1", errCntDef - baseErr); end
        vectors++; if (nSetDef - baseSet !== 1) begin miscompares++; $display("[TB] FAIL ill_nset got %0d want 1", nSetDef - baseSet); end
        vectors++; if ((nClrDef - baseClr) + (nTglDef - baseTgl) !== 0) begin miscompares++; $display("[TB] FAIL ill_others got %0d want 0", (nClrDef - baseClr) + (nTglDef - baseTgl)); end
    endtask

    task automatic test_hold_gap();
        int baseClr;
        logic [1:0] want;
        baseClr = nClrH3;
        validH3 = 1'b1; cmdH3 = 2'b01;
        step();
        validH3 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            want = (i <= 3) ? 2'b01 : 2'b00;
            vectors++;
            if (aoutH3 !== want) begin
                miscompares++;
                $display("[TB] FAIL hg_aout[%0d] got %b want %b", i, aoutH3, want);
            end
            if (i == 7) begin
                vectors++; if (busyH3 !== 1'b1) begin miscompares++; $display("[TB] FAIL hg_busy7 got %b want 1", busyH3); end
            end
            if (i == 8) begin
                vectors++; if (busyH3 !== 1'b0) begin miscompares++; $display("[TB] FAIL hg_busy8 got %b want 0", busyH3); end
            end
        end
        vectors++; if (nClrH3 - baseClr !== 1) begin miscompares++; $display("[TB] FAIL hg_nclr got %0d want 1", nClrH3 - baseClr); end
    endtask

    task automatic test_reset_mid_send();
        int snapTotal;
        validH3 = 1'b1; cmdH3 = 2'b11;
        step();
        cmdH3 = 2'b10;
        step();
        cmdH3 = 2'b01;
        step();
        validH3 = 1'b0;
        vectors++; if (countH3 !== 3'd2) begin miscompares++; $display("[TB] FAIL rms_queued got %0d want 2", countH3); end
        vectors++; if (aoutH3 !== 2'b11) begin miscompares++; $display("[TB] FAIL rms_sending got %b want 11", aoutH3); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (aoutH3 !== 2'b00) begin miscompares++; $display("[TB] FAIL rms_aout got %b want 00", aoutH3); end
        vectors++; if (countH3 !== 3'd0) begin miscompares++; $display("[TB] FAIL rms_count got %0d want 0", countH3); end
        vectors++; if (readyH3 !== 1'b0) begin miscompares++; $display("[TB] FAIL rms_ready got %b want 0", readyH3); end
        vectors++; if (busyH3 !== 1'b0) begin miscompares++; $display("[TB] FAIL rms_busy got %b want 0", busyH3); end
        step();
        reset = 1'b1;
        snapTotal = nSetH3 + nClrH3 + nTglH3;
        #1;
        vectors++; if (readyH3 !== 1'b1) begin miscompares++; $display("[TB] FAIL rms_rel_ready got %b want 1", readyH3); end
        for (int i = 0; i < 12; i++) begin
            step();
            vectors++;
            if (aoutH3 !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL rms_quiet[%0d] got %b want 00", i, aoutH3);
            end
        end
        vectors++; if (busyH3 !== 1'b0) begin miscompares++; $display("[TB] FAIL rms_rel_busy got %b want 0", busyH3); end
        vectors++; if (nSetH3 + nClrH3 + nTglH3 !== snapTotal) begin miscompares++; $display("[TB] FAIL rms_replay got %0d want %0d", nSetH3 + nClrH3 + nTglH3, snapTotal); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_single_set();
        test_back_to_back();
        test_fill();
        test_illegal();
        test_hold_gap();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
